muldiv_hilo_unit: RTL and testbench

Multi-cycle HI/LO unit that sits beside the EX-stage ALU in the MIPS pipeline. It owns the division iteration state: counter, 64-bit shift register and divisor. It performs unsigned 32-iteration restoring division and single-cycle unsigned multiply, and holds the architectural HI/LO registers read by mfhi/mflo. While a division is in flight it drives the pipeline stall; the ALU itself stays purely combinational.

---
 rtl/muldiv_hilo_unit_pkg.sv | 19 +
 rtl/muldiv_hilo_unit_if.sv | 28 ++
 rtl/muldiv_hilo_unit_div_step.sv | 26 ++
 rtl/muldiv_hilo_unit.sv | 115 +++++++++++
 tb/tb_muldiv_hilo_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: FSM states, ALU control codes, step count.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  // ALU control encodings that EX decodes into start_div_i / start_mult_i.
  localparam logic [3:0] CTRL_DIV  = 4'b0011;
  localparam logic [3:0] CTRL_MULT = 4'b1100;

  // One restoring-division iteration per quotient bit.
  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// EX-stage <-> HI/LO unit bundle: start/cancel requests, operands, stall, result registers.
// Latency: n/a (wires only).
// Backpressure: busy_o is the stall back toward the pipeline.
// master = pipeline side (drives starts/operands), slave = the HI/LO unit.
interface muldiv_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_div_i;
  logic             start_mult_i;
  logic             cancel_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             busy_o;
  logic             done_o;
  logic             div_by_zero_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_div_i, start_mult_i, cancel_i, src1_i, src2_i,
    input  busy_o, done_o, div_by_zero_o, hi_o, lo_o
  );

  modport slave (
    input  start_div_i, start_mult_i, cancel_i, src1_i, src2_i,
    output busy_o, done_o, div_by_zero_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_hilo_unit_div_step.sv
// One restoring-division iteration: shift the {remainder, quotient} pair left, subtract if it fits.
// Latency: combinational.
// Backpressure: none.
// Ports: acc_i = current {rem, quo}, div_i = divisor, acc_o = {rem, quo} after this step.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   div_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] acc_s;
  logic [WIDTH-1:0]   upper;

  always_comb begin
    acc_s = acc_i << 1;
    upper = acc_s[2*WIDTH-1:WIDTH];
    acc_o = acc_s;
    if (upper >= div_i) begin
      acc_o[2*WIDTH-1:WIDTH] = upper - div_i;
      acc_o[0]               = 1'b1;  // quotient bit lands in the vacated LSB
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// HI/LO unit beside the EX ALU: single-cycle unsigned multiply, WIDTH-step restoring divide.
// Latency: multu 1 cycle; divu WIDTH+1 cycles to results (done_o then), divide-by-zero 1 cycle.
// Backpressure: busy_o stalls the pipeline from the divu issue cycle until the last step.
// Ports: clk_i, rst_i (async active-low), bus (slave side of muldiv_hilo_unit_if).
module muldiv_hilo_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = DIV_STEPS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  muldiv_hilo_unit_if.slave bus
);

  localparam int              CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     div_q, div_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 dbz_q, dbz_d;

  logic                 accepting;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   product;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .acc_i (acc_q),
    .div_i (div_q),
    .acc_o (acc_step)
  );

  assign accepting = (state_q != ST_DIV);
  assign product   = {{WIDTH{1'b0}}, bus.src1_i} * {{WIDTH{1'b0}}, bus.src2_i};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;

    if (state_q == ST_DIV) begin
      if (bus.cancel_i) begin
        // Flush abandons the division; architectural HI/LO keep their old values.
        state_d = ST_IDLE;
      end else begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          // Commit straight from the step output so results appear one cycle earlier.
          lo_d    = acc_step[WIDTH-1:0];
          hi_d    = acc_step[2*WIDTH-1:WIDTH];
          state_d = ST_DONE;
        end
      end
    end else begin
      // IDLE or DONE: DONE lasts one cycle unless a new division is taken.
      state_d = ST_IDLE;
      if (!bus.cancel_i) begin
        if (bus.start_div_i) begin
          if (bus.src2_i == '0) begin
            lo_d    = '1;
            hi_d    = bus.src1_i;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, bus.src1_i};
            div_d   = bus.src2_i;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = ST_DIV;
          end
        end else if (bus.start_mult_i) begin
          hi_d = product[2*WIDTH-1:WIDTH];
          lo_d = product[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      div_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  // Stall covers the issue cycle of a real (nonzero-divisor) division as well.
  assign bus.busy_o        = (state_q == ST_DIV) ||
                             (accepting && bus.start_div_i && !bus.cancel_i && (bus.src2_i != '0));
  assign bus.done_o        = (state_q == ST_DONE);
  assign bus.div_by_zero_o = dbz_q;
  assign bus.hi_o          = hi_q;
  assign bus.lo_o          = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit: divide vector table plus multiply/cancel/reset sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_muldiv_hilo_unit;

  logic clk_i = 1'b0;
  logic rst_i;

  muldiv_hilo_unit_if #(.WIDTH(32)) bus ();

  muldiv_hilo_unit #(.WIDTH(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        exp_dbz;
    int          exp_busy;
    int          exp_done_cyc;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_inputs();
    bus.start_div_i  = 1'b0;
    bus.start_mult_i = 1'b0;
    bus.cancel_i     = 1'b0;
  endtask

  // Issue a divu in the current cycle (cycle 0), then follow it until done_o.
  // Returns the number of cycles with busy_o high and the cycle index of done_o (-1 if never).
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output int nbusy, output int done_cyc);
    nbusy    = 0;
    done_cyc = -1;
    bus.start_div_i = 1'b1;
    bus.src1_i      = a;
    bus.src2_i      = b;
    #1;
    for (int c = 0; c <= 60; c++) begin
      if (bus.busy_o) nbusy++;
      // done_o in cycle 0 belongs to a previous division.
      if (c > 0 && bus.done_o) begin
        done_cyc = c;
        break;
      end
      @(posedge clk_i); #1;
      clear_inputs();
      #1;
    end
  endtask

  initial begin
    int nbusy, done_cyc, ndone;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33, 33};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33, 33};
    vecs[2] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 33, 33};
    vecs[3] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 0,  1};
    vecs[4] = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 33, 33};
    vecs[5] = '{32'd7,          32'd100,        32'd0,          32'd7,          1'b0, 33, 33};
    vecs[6] = '{32'd1000,       32'd10,         32'd100,        32'd0,          1'b0, 33, 33};
    vecs[7] = '{32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          1'b0, 33, 33};

    // Reset state
    rst_i = 1'b0;
    clear_inputs();
    bus.src1_i = '0;
    bus.src2_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_dbz",  32'(bus.div_by_zero_o), 32'd0);
    chk("rst_hi",   bus.hi_o, 32'd0);
    chk("rst_lo",   bus.lo_o, 32'd0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // multu 0xFFFFFFFF * 2 -> {1, 0xFFFFFFFE} in cycle 1, no stall
    bus.start_mult_i = 1'b1;
    bus.src1_i       = 32'hFFFF_FFFF;
    bus.src2_i       = 32'd2;
    #1;
    chk("mult_busy_c0", 32'(bus.busy_o), 32'd0);
    @(posedge clk_i); #1;
    clear_inputs();
    chk("mult_hi", bus.hi_o, 32'd1);
    chk("mult_lo", bus.lo_o, 32'hFFFF_FFFE);
    chk("mult_done", 32'(bus.done_o), 32'd0);

    // Divide table, issued back-to-back (each start lands in the previous DONE cycle)
    for (int i = 0; i < 8; i++) begin
      run_div(vecs[i].a, vecs[i].b, nbusy, done_cyc);
      chk($sformatf("v%0d_busy_cycles", i), 32'(nbusy), 32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_done_cycle", i), 32'(done_cyc), 32'(vecs[i].exp_done_cyc));
      chk($sformatf("v%0d_lo", i), bus.lo_o, vecs[i].exp_lo);
      chk($sformatf("v%0d_hi", i), bus.hi_o, vecs[i].exp_hi);
      chk($sformatf("v%0d_dbz", i), 32'(bus.div_by_zero_o), 32'(vecs[i].exp_dbz));
    end

    // multu while DIV is running is ignored; division result stands
    @(posedge clk_i); #1;
    bus.start_div_i = 1'b1;
    bus.src1_i      = 32'd100;
    bus.src2_i      = 32'd7;
    done_cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk_i); #1;
      clear_inputs();
      if (c <= 5) begin
        bus.start_mult_i = 1'b1;
        bus.src1_i       = 32'hFFFF_FFFF;
        bus.src2_i       = 32'd2;
      end
      #1;
      if (c == 1) chk("divmult_busy_c1", 32'(bus.busy_o), 32'd1);
      if (bus.done_o) begin
        done_cyc = c;
        break;
      end
    end
    chk("divmult_done_cycle", 32'(done_cyc), 32'd33);
    chk("divmult_lo", bus.lo_o, 32'd14);
    chk("divmult_hi", bus.hi_o, 32'd2);

    // Preload HI/LO = 0xAAAA/0x5555: 0xAAAAAAAB * 0xFFFF = 0x0000AAAA_00005555
    @(posedge clk_i); #1;
    bus.start_mult_i = 1'b1;
    bus.src1_i       = 32'hAAAA_AAAB;
    bus.src2_i       = 32'h0000_FFFF;
    @(posedge clk_i); #1;
    clear_inputs();
    chk("preload_hi", bus.hi_o, 32'h0000_AAAA);
    chk("preload_lo", bus.lo_o, 32'h0000_5555);

    // Start 100/7, cancel in cycle 10
    bus.start_div_i = 1'b1;
    bus.src1_i      = 32'd100;
    bus.src2_i      = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk_i); #1;
      clear_inputs();
    end
    bus.cancel_i = 1'b1;
    #1;
    chk("cancel_busy_c10", 32'(bus.busy_o), 32'd1);
    @(posedge clk_i); #1;
    clear_inputs();
    #1;
    chk("cancel_busy_c11", 32'(bus.busy_o), 32'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done_o) ndone++;
      @(posedge clk_i); #2;
    end
    chk("cancel_no_done", 32'(ndone), 32'd0);
    chk("cancel_hi", bus.hi_o, 32'h0000_AAAA);
    chk("cancel_lo", bus.lo_o, 32'h0000_5555);
    chk("cancel_dbz", 32'(bus.div_by_zero_o), 32'd0);

    // cancel_i beats start_div_i when accepting
    bus.cancel_i    = 1'b1;
    bus.start_div_i = 1'b1;
    bus.src1_i      = 32'd9;
    bus.src2_i      = 32'd3;
    #1;
    chk("cancel_prio_busy", 32'(bus.busy_o), 32'd0);
    @(posedge clk_i); #1;
    clear_inputs();
    chk("cancel_prio_done", 32'(bus.done_o), 32'd0);
    chk("cancel_prio_lo", bus.lo_o, 32'h0000_5555);

    // Asynchronous reset mid-division at iteration 20
    bus.start_div_i = 1'b1;
    bus.src1_i      = 32'd100;
    bus.src2_i      = 32'd7;
    for (int c = 1; c <= 21; c++) begin
      @(posedge clk_i); #1;
      clear_inputs();
    end
    #3;
    rst_i = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy_o), 32'd0);
    chk("arst_done", 32'(bus.done_o), 32'd0);
    chk("arst_dbz",  32'(bus.div_by_zero_o), 32'd0);
    chk("arst_hi",   bus.hi_o, 32'd0);
    chk("arst_lo",   bus.lo_o, 32'd0);
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    run_div(32'd100, 32'd7, nbusy, done_cyc);
    chk("post_rst_busy_cycles", 32'(nbusy), 32'd33);
    chk("post_rst_done_cycle", 32'(done_cyc), 32'd33);
    chk("post_rst_lo", bus.lo_o, 32'd14);
    chk("post_rst_hi", bus.hi_o, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
